// File: rtl/dec_sched_pkg.sv
// Shared types and constants for the dec_sched timer scheduler.
//   chan_state_e : per-channel FSM state (IDLE / RUN)
//   chan_idx_t   : channel index for the default four-channel build
package dec_sched_pkg;

  localparam int unsigned DecSchedMinWidth    = 2;
  localparam int unsigned DecSchedNumChanDflt = 4;
  localparam int unsigned DecSchedChanW       = $clog2(DecSchedNumChanDflt);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_e;

  typedef logic [DecSchedChanW-1:0] chan_idx_t;

endpackage

// File: rtl/Dec.sv
// Dec: combinational decrement-by-one, y = a - 1 (modulo 2^width).
//   width : word width
//   speed : 0 serial borrow chain, otherwise parallel-prefix form
//   a     : operand
//   y     : a - 1
module Dec #(
  parameter int unsigned width = 8,
  parameter int unsigned speed = 0
) (
  input  logic [width-1:0] a,
  output logic [width-1:0] y
);

  if (speed == 0) begin : g_serial
    // Ripple borrow: bit i flips while every lower bit of a is zero.
    always_comb begin
      logic borrow;
      borrow = 1'b1;
      y      = '0;
      for (int i = 0; i < int'(width); i++) begin
        y[i]   = a[i] ^ borrow;
        borrow = borrow & ~a[i];
      end
    end
  end else begin : g_prefix
    assign y = a - width'(1);
  end

endmodule

// File: rtl/dec_sched.sv
// dec_sched: round-robin down-counter scheduler sharing one Dec among
// NumChan timer channels. Optional periodic mode under DEC_SCHED_RELOAD_EN.
//   clk_i, rst_ni        : clock, async active-low reset
//   en_i                 : advance pointer and decrement visited channel
//   load_valid_i/ready_o : load handshake (ready high whenever out of reset)
//   load_chan_i/value_i  : load target and start count (0 cancels)
//   rd_chan_i/rd_value_o : combinational count read port
//   expire_o             : registered one-cycle expiry pulse per channel
//   busy_o               : OR of all channel RUN states
module dec_sched
  import dec_sched_pkg::*;
#(
  parameter int unsigned width   = 8,
  parameter int unsigned speed   = 0,
  parameter int unsigned NumChan = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic                       load_valid_i,
  output logic                       load_ready_o,
  input  logic [$clog2(NumChan)-1:0] load_chan_i,
  input  logic [width-1:0]           load_value_i,
  input  logic [$clog2(NumChan)-1:0] rd_chan_i,
  output logic [width-1:0]           rd_value_o,
  output logic [NumChan-1:0]         expire_o,
  output logic                       busy_o
);

  localparam int unsigned ChanW = $clog2(NumChan);
  localparam logic [ChanW-1:0] LastChan = ChanW'(NumChan - 1);

  logic [ChanW-1:0]   ptr_q, ptr_d;
  logic [width-1:0]   cnt_q [NumChan];
  logic [width-1:0]   cnt_d [NumChan];
  chan_state_e        state_q [NumChan];
  chan_state_e        state_d [NumChan];
  logic [NumChan-1:0] expire_d;
  logic               ready_q;
  logic [width-1:0]   dec_in, dec_out;
  logic               visit_last;
  logic               load_fire;
`ifdef DEC_SCHED_RELOAD_EN
  logic [width-1:0]   reload_q [NumChan];
  logic [width-1:0]   reload_d [NumChan];
`endif

  // The single shared decrementer sees the channel under the pointer.
  assign dec_in     = cnt_q[ptr_q];
  assign visit_last = (dec_in == width'(1));
  assign load_fire  = load_valid_i & ready_q;

  Dec #(
    .width(width),
    .speed(speed)
  ) u_dec (
    .a(dec_in),
    .y(dec_out)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      expire_o <= '0;
      ready_q  <= 1'b0;
      for (int i = 0; i < int'(NumChan); i++) begin
        cnt_q[i]    <= '0;
        state_q[i]  <= IDLE;
`ifdef DEC_SCHED_RELOAD_EN
        reload_q[i] <= '0;
`endif
      end
    end else begin
      ptr_q    <= ptr_d;
      expire_o <= expire_d;
      ready_q  <= 1'b1;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
`ifdef DEC_SCHED_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  // Next state: visit first, then a load overrides the same channel.
  always_comb begin
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    expire_d = '0;
`ifdef DEC_SCHED_RELOAD_EN
    reload_d = reload_q;
`endif

    if (en_i) begin
      ptr_d = (ptr_q == LastChan) ? '0 : ptr_q + ChanW'(1);
      if (state_q[ptr_q] == RUN) begin
        expire_d[ptr_q] = visit_last;
`ifdef DEC_SCHED_RELOAD_EN
        cnt_d[ptr_q] = visit_last ? reload_q[ptr_q] : dec_out;
`else
        cnt_d[ptr_q] = dec_out;
        if (visit_last) begin
          state_d[ptr_q] = IDLE;
        end
`endif
      end
    end

    if (load_fire) begin
      cnt_d[load_chan_i]    = load_value_i;
      expire_d[load_chan_i] = 1'b0;
      state_d[load_chan_i]  = (load_value_i != '0) ? RUN : IDLE;
`ifdef DEC_SCHED_RELOAD_EN
      reload_d[load_chan_i] = load_value_i;
`endif
    end
  end

  // Busy reflects the registered channel states.
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < int'(NumChan); i++) begin
      busy_o = busy_o | (state_q[i] == RUN);
    end
  end

  assign load_ready_o = ready_q;
  assign rd_value_o   = cnt_q[rd_chan_i];

endmodule

// File: tb/tb_dec_sched.sv
// Directed self-checking bench for dec_sched (width=8, NumChan=4).
module tb_dec_sched;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       en_i;
  logic       load_valid_i;
  logic       load_ready_o;
  logic [1:0] load_chan_i;
  logic [7:0] load_value_i;
  logic [1:0] rd_chan_i;
  logic [7:0] rd_value_o;
  logic [3:0] expire_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dec_sched #(
    .width(8),
    .speed(0),
    .NumChan(4)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .en_i(en_i),
    .load_valid_i(load_valid_i),
    .load_ready_o(load_ready_o),
    .load_chan_i(load_chan_i),
    .load_value_i(load_value_i),
    .rd_chan_i(rd_chan_i),
    .rd_value_o(rd_value_o),
    .expire_o(expire_o),
    .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt;
    logic [3:0] exp_exp;
    logic seen;

    // Reset with random inputs: every output held low.
    rst_ni       = 1'b0;
    en_i         = 1'b0;
    load_valid_i = 1'b0;
    load_chan_i  = 2'd0;
    load_value_i = 8'd0;
    rd_chan_i    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      en_i         = 1'($urandom);
      load_valid_i = 1'($urandom);
      load_chan_i  = 2'($urandom);
      load_value_i = 8'($urandom);
      rd_chan_i    = 2'($urandom);
      step();
      chk("rst_expire", 32'(expire_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_ready", 32'(load_ready_o), 32'd0);
      chk("rst_rd", 32'(rd_value_o), 32'd0);
    end
    en_i         = 1'b0;
    load_valid_i = 1'b0;
    rd_chan_i    = 2'd0;
    rst_ni       = 1'b1;
    #1;
    chk("ready_before_edge", 32'(load_ready_o), 32'd0);
    step();
    chk("ready_after_release", 32'(load_ready_o), 32'd1);

    // Single expiry: ch0 <- 3 with ptr 0 -> 1; decrements at E+4, E+8, E+12.
    en_i         = 1'b1;
    load_valid_i = 1'b1;
    load_chan_i  = 2'd0;
    load_value_i = 8'd3;
    step();
    load_valid_i = 1'b0;
    chk("single_load_rd", 32'(rd_value_o), 32'd3);
    chk("single_load_busy", 32'(busy_o), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_cnt = 3 - k / 4;
      chk("single_cnt", 32'(rd_value_o), 32'(exp_cnt));
      chk("single_expire", 32'(expire_o), (k == 12) ? 32'h1 : 32'h0);
      chk("single_busy", 32'(busy_o), (k < 12) ? 32'd1 : 32'd0);
    end
    step();
    chk("single_pulse_end", 32'(expire_o), 32'd0);

    // Pause: ch0 <- 3 with ptr 2 -> 3; en low over 5 edges stretches expiry to F+15.
    load_valid_i = 1'b1;
    load_chan_i  = 2'd0;
    load_value_i = 8'd3;
    step();
    load_valid_i = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      en_i = (k >= 4 && k <= 8) ? 1'b0 : 1'b1;
      step();
      if (k < 2)       exp_cnt = 3;
      else if (k < 11) exp_cnt = 2;
      else if (k < 15) exp_cnt = 1;
      else             exp_cnt = 0;
      chk("pause_cnt", 32'(rd_value_o), 32'(exp_cnt));
      chk("pause_expire", 32'(expire_o), (k == 15) ? 32'h1 : 32'h0);
    end
    en_i = 1'b1;
    step();
    chk("pause_pulse_end", 32'(expire_o), 32'd0);

    // Collision: ch2 <- 1 with ptr 2 -> 3; reload ch2 <- 7 on its visit at G+4.
    rd_chan_i    = 2'd2;
    load_valid_i = 1'b1;
    load_chan_i  = 2'd2;
    load_value_i = 8'd1;
    step();
    load_valid_i = 1'b0;
    step();
    step();
    step();
    chk("coll_pre_cnt", 32'(rd_value_o), 32'd1);
    load_valid_i = 1'b1;
    load_value_i = 8'd7;
    step();
    load_valid_i = 1'b0;
    chk("coll_cnt", 32'(rd_value_o), 32'd7);
    chk("coll_no_pulse", 32'(expire_o), 32'd0);
    for (int k = 5; k <= 32; k++) begin
      step();
      exp_cnt = 7 - (k - 4) / 4;
      chk("coll_run_cnt", 32'(rd_value_o), 32'(exp_cnt));
      chk("coll_expire", 32'(expire_o), (k == 32) ? 32'h4 : 32'h0);
    end

    // Cancel: ch1 <- 5, then ch1 <- 0 before expiry.
    rd_chan_i    = 2'd1;
    load_valid_i = 1'b1;
    load_chan_i  = 2'd1;
    load_value_i = 8'd5;
    step();
    load_valid_i = 1'b0;
    chk("cancel_load_busy", 32'(busy_o), 32'd1);
    step();
    step();
    load_valid_i = 1'b1;
    load_value_i = 8'd0;
    step();
    load_valid_i = 1'b0;
    chk("cancel_cnt", 32'(rd_value_o), 32'd0);
    chk("cancel_busy", 32'(busy_o), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      seen = seen | (expire_o != 4'd0);
    end
    chk("cancel_no_pulse", 32'(seen), 32'd0);

    // Reset mid-count aborts everything without a pulse.
    rd_chan_i    = 2'd0;
    load_valid_i = 1'b1;
    load_chan_i  = 2'd0;
    load_value_i = 8'd9;
    step();
    load_valid_i = 1'b0;
    step();
    rst_ni = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_rd", 32'(rd_value_o), 32'd0);
    chk("midrst_ready", 32'(load_ready_o), 32'd0);
    step();
    step();
    chk("midrst_expire", 32'(expire_o), 32'd0);
    en_i   = 1'b0;
    rst_ni = 1'b1;
    step();
    chk("midrst_ready_back", 32'(load_ready_o), 32'd1);

    // Reload: ch3 <- 2 with ptr 0 -> 1; decrements at I+3+4j, first expiry after I+7.
    rd_chan_i    = 2'd3;
    en_i         = 1'b1;
    load_valid_i = 1'b1;
    load_chan_i  = 2'd3;
    load_value_i = 8'd2;
    step();
    load_valid_i = 1'b0;
    chk("reload_load_rd", 32'(rd_value_o), 32'd2);
    for (int k = 1; k <= 24; k++) begin
      step();
`ifdef DEC_SCHED_RELOAD_EN
      exp_cnt = (k % 8 >= 3 && k % 8 <= 6) ? 1 : 2;
      exp_exp = (k % 8 == 7) ? 4'h8 : 4'h0;
      chk("reload_busy", 32'(busy_o), 32'd1);
`else
      if (k < 3)      exp_cnt = 2;
      else if (k < 7) exp_cnt = 1;
      else            exp_cnt = 0;
      exp_exp = (k == 7) ? 4'h8 : 4'h0;
      chk("reload_busy", 32'(busy_o), (k < 7) ? 32'd1 : 32'd0);
`endif
      chk("reload_cnt", 32'(rd_value_o), 32'(exp_cnt));
      chk("reload_expire", 32'(expire_o), 32'(exp_exp));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
